// File: rtl/shift_add_mul.sv
// shift_add_mul: sequential WIDTH x WIDTH unsigned shift-add multiplier.
// Start/done handshake. A multiply takes WIDTH RUN cycles, then one DONE cycle.
// Optional macro SHIFT_ADD_MUL_EARLY_TERM_EN: RUN ends once no multiplier bits
// remain, so the latency depends on the data. The product is the same either way.
module shift_add_mul #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] product_hi,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     prod_lo_q, prod_lo_d;
    logic [WIDTH-1:0]     prod_hi_q, prod_hi_d;
    logic                 ovf_q, ovf_d;

    logic [2*WIDTH-1:0]   acc_sum;
    logic                 last_iter;

    // Next-state, datapath and result capture
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        prod_lo_d = prod_lo_q;
        prod_hi_d = prod_hi_q;
        ovf_d     = ovf_q;

        acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
        last_iter = (cnt_q == CW'(WIDTH - 1)) || ((mplier_q >> 1) == '0);
`else
        last_iter = (cnt_q == CW'(WIDTH - 1));
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE accepts start just like IDLE for back-to-back operation
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (last_iter) begin
                    // Capture includes this cycle's partial product
                    prod_lo_d = acc_sum[WIDTH-1:0];
                    prod_hi_d = acc_sum[2*WIDTH-1:WIDTH];
                    ovf_d     = |acc_sum[2*WIDTH-1:WIDTH];
                    state_d   = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            prod_lo_q <= '0;
            prod_hi_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            prod_lo_q <= prod_lo_d;
            prod_hi_q <= prod_hi_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign product_lo = prod_lo_q;
    assign product_hi = prod_hi_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_shift_add_mul.sv
// tb_shift_add_mul: randomized self-checking bench for shift_add_mul.
// The reference is plain a*b. Latency is counted as rising edges after the
// accepted start edge until done is observed: WIDTH normally, or
// (msb index of b)+1 when SHIFT_ADD_MUL_EARLY_TERM_EN is defined (1 for b=0).
module tb_shift_add_mul;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, ovf;
    logic [W-1:0] product_lo, product_hi;

    int errors = 0;
    int checks = 0;

    shift_add_mul #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .product_lo (product_lo),
        .product_hi (product_hi),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        return p;
    endfunction

    function automatic int ref_latency(input logic [W-1:0] y);
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
        int msb;
        msb = 0;
        for (int i = 0; i < W; i++) if (y[i]) msb = i;
        return msb + 1;
`else
        return (y == '0) ? W : W;
`endif
    endfunction

    // Pulse start for one cycle at the accepting edge, then scramble a/b
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
    endtask

    // Count edges until done (bounded); optional start re-pulse during RUN
    task automatic wait_done(input int repulse_at, output int edges,
                             output int busy_cycles, output bit overlap);
        edges = 0; busy_cycles = 0; overlap = 1'b0;
        while (!done && edges < 40) begin
            if (busy) busy_cycles++;
            if (busy && done) overlap = 1'b1;
            if (edges == repulse_at) begin
                a = 16'd2; b = 16'd2; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start = 1'b0;
        if (busy && done) overlap = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, ovf, product_hi, product_lo} !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b ovf=%b prod=%h%h, want all 0",
                     busy, done, ovf, product_hi, product_lo);
        end
    endtask

    task automatic test_basic();
        int e, bc; bit ov;
        start_op(16'd3, 16'd5);
        wait_done(-1, e, bc, ov);
        checks++;
        if (e !== W) begin errors++; $display("FAIL basic_latency: got %0d want %0d", e, W); end
        checks++;
        if (bc !== W) begin errors++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, W); end
        checks++;
        if ({ovf, product_hi, product_lo} !== {1'b0, 16'd0, 16'd15}) begin
            errors++;
            $display("FAIL basic_product: got ovf=%b %h_%h want 0 0000_000f", ovf, product_hi, product_lo);
        end
        checks++;
        if (ov) begin errors++; $display("FAIL basic_overlap: busy and done both high, want never"); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL basic_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_max();
        int e, bc; bit ov; bit held;
        start_op(16'hFFFF, 16'hFFFF);
        wait_done(-1, e, bc, ov);
        checks++;
        if ({ovf, product_hi, product_lo} !== {1'b1, 16'hFFFE, 16'h0001}) begin
            errors++;
            $display("FAIL max_product: got ovf=%b %h_%h want 1 fffe_0001", ovf, product_hi, product_lo);
        end
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({ovf, product_hi, product_lo, done, busy} !== {1'b1, 16'hFFFE, 16'h0001, 2'b00}) held = 1'b0;
        end
        checks++;
        if (!held) begin errors++; $display("FAIL max_hold: outputs changed while idle, want held fffe_0001"); end
    endtask

    task automatic test_random();
        int e, bc; bit ov;
        logic [W-1:0] x, y;
        logic [2*W-1:0] p;
        for (int n = 0; n < 10; n++) begin
            x = W'($urandom);
            y = W'($urandom) >> $urandom_range(0, W - 1);
            p = ref_product(x, y);
            start_op(x, y);
            wait_done(-1, e, bc, ov);
            checks++;
            if ({product_hi, product_lo} !== p || ovf !== (p[2*W-1:W] != '0)) begin
                errors++;
                $display("FAIL random_product: %h*%h got ovf=%b %h%h want ovf=%b %h",
                         x, y, ovf, product_hi, product_lo, (p[2*W-1:W] != '0), p);
            end
            checks++;
            if (e !== ref_latency(y)) begin
                errors++; $display("FAIL random_latency: b=%h got %0d want %0d", y, e, ref_latency(y));
            end
        end
    endtask

    task automatic test_restart_ignored();
        int e, bc, extra; bit ov;
        start_op(16'd7, 16'd9);
        wait_done(4, e, bc, ov);
        checks++;
        if (e !== ref_latency(16'd9) || {product_hi, product_lo} !== 32'd63) begin
            errors++;
            $display("FAIL restart_ignored: got lat=%0d prod=%h%h want lat=%0d prod=0000003f",
                     e, product_hi, product_lo, ref_latency(16'd9));
        end
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL restart_single_done: got %0d extra done want 0", extra); end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        start_op(16'd100, 16'd100);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, ovf, product_hi, product_lo} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b ovf=%b prod=%h%h want all 0",
                     busy, done, ovf, product_hi, product_lo);
        end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reset_no_done: got %0d active cycles want 0", seen); end
    endtask

    task automatic test_back_to_back();
        int e;
        @(negedge clk);
        a = 16'd4; b = 16'd6; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        e = 0;
        while (!done && e < 40) begin
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        checks++;
        if ({product_hi, product_lo} !== 32'd24 || e !== ref_latency(16'd6)) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d prod=%h%h want lat=%0d prod=00000018",
                     e, product_hi, product_lo, ref_latency(16'd6));
        end
        // DONE cycle: present new operands with start still high
        a = 16'd10; b = 16'd10;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++; $display("FAIL b2b_accept: busy=%b done=%b want 1 0", busy, done);
        end
        e = 0;
        while (!done && e < 40) begin
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        checks++;
        if ({product_hi, product_lo} !== 32'd100 || e !== ref_latency(16'd10)) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d prod=%h%h want lat=%0d prod=00000064",
                     e, product_hi, product_lo, ref_latency(16'd10));
        end
    endtask

    task automatic test_early_term();
        int e, bc; bit ov;
        start_op(16'd7, 16'd2);
        wait_done(-1, e, bc, ov);
        checks++;
        if ({product_hi, product_lo} !== 32'd14 || e !== ref_latency(16'd2)) begin
            errors++;
            $display("FAIL early_7x2: got lat=%0d prod=%h%h want lat=%0d prod=0000000e",
                     e, product_hi, product_lo, ref_latency(16'd2));
        end
        start_op(16'd5, 16'd0);
        wait_done(-1, e, bc, ov);
        checks++;
        if ({ovf, product_hi, product_lo} !== '0 || e !== ref_latency(16'd0)) begin
            errors++;
            $display("FAIL early_5x0: got lat=%0d ovf=%b prod=%h%h want lat=%0d 0",
                     e, ovf, product_hi, product_lo, ref_latency(16'd0));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_random();
        test_restart_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_early_term();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
